// File: rtl/rs_glb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// rs_glb_fetch_ctrl
//
// Read sequencer placed directly after the row-stationary global buffer.
// One start runs an optional weight phase followed by an fmap phase. Each
// phase walks its address counter from 0 to DEPTH-1 and streams one
// registered beat per address to the PE-array loader over valid/ready.
// A one-cycle done pulse closes the run.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_i           start request, honoured only while idle
//   weight_skip_i     sampled with start_i; 1 skips the weight phase
//   glb_cs_o          buffer chip select (bit0 fmaps, bit1 weight)
//   glb_we_o          buffer write enable, tied low (read-only client)
//   fmaps_addr_o      fmap read address
//   weight_addr_o     weight read address
//   fmaps_data_i      combinational fmap read data, rows 1..7
//   weight_data_i     combinational weight read data, rows 1..5
//   w_data_o/w_idx_o/w_valid_o/w_ready_i   weight beat stream
//   f_data_o/f_idx_o/f_valid_o/f_ready_i   fmap beat stream
//   busy_o            high whenever a run is in progress
//   done_o            one-cycle pulse at the end of a completed run
// ---------------------------------------------------------------------------
module rs_glb_fetch_ctrl #(
    parameter int FMAP_DEPTH   = 19,
    parameter int WEIGHT_DEPTH = 38,
    parameter int F_AW         = 5,
    parameter int W_AW         = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            weight_skip_i,
    output logic [1:0]      glb_cs_o,
    output logic [1:0]      glb_we_o,
    output logic [F_AW-1:0] fmaps_addr_o,
    output logic [W_AW-1:0] weight_addr_o,
    input  logic [55:0]     fmaps_data_i,
    input  logic [39:0]     weight_data_i,
    output logic [39:0]     w_data_o,
    output logic [W_AW-1:0] w_idx_o,
    output logic            w_valid_o,
    input  logic            w_ready_i,
    output logic [55:0]     f_data_o,
    output logic [F_AW-1:0] f_idx_o,
    output logic            f_valid_o,
    input  logic            f_ready_i,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_FETCH = 3'd1,
        W_DRAIN = 3'd2,
        F_FETCH = 3'd3,
        F_DRAIN = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [W_AW-1:0] W_LAST = W_AW'(WEIGHT_DEPTH - 1);
    localparam logic [F_AW-1:0] F_LAST = F_AW'(FMAP_DEPTH - 1);

    state_t          state_q, state_d;
    logic [W_AW-1:0] waddr_q, waddr_d;
    logic [F_AW-1:0] faddr_q, faddr_d;
    logic [39:0]     w_data_q, w_data_d;
    logic [W_AW-1:0] w_idx_q, w_idx_d;
    logic            w_valid_q, w_valid_d;
    logic [55:0]     f_data_q, f_data_d;
    logic [F_AW-1:0] f_idx_q, f_idx_d;
    logic            f_valid_q, f_valid_d;
    logic [1:0]      cs;

    // Every register, data included, clears on reset so that all outputs
    // read zero on the cycle after reset is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            faddr_q   <= '0;
            w_data_q  <= '0;
            w_idx_q   <= '0;
            w_valid_q <= 1'b0;
            f_data_q  <= '0;
            f_idx_q   <= '0;
            f_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            faddr_q   <= faddr_d;
            w_data_q  <= w_data_d;
            w_idx_q   <= w_idx_d;
            w_valid_q <= w_valid_d;
            f_data_q  <= f_data_d;
            f_idx_q   <= f_idx_d;
            f_valid_q <= f_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        faddr_d   = faddr_q;
        w_data_d  = w_data_q;
        w_idx_d   = w_idx_q;
        w_valid_d = w_valid_q;
        f_data_d  = f_data_q;
        f_idx_d   = f_idx_q;
        f_valid_d = f_valid_q;
        cs        = 2'b00;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (weight_skip_i) begin
                        faddr_d = '0;
                        state_d = F_FETCH;
                    end else begin
                        waddr_d = '0;
                        state_d = W_FETCH;
                    end
                end
            end

            W_FETCH: begin
                cs = 2'b10;
                // The buffer read is combinational, so the word at waddr_q
                // is present this cycle; capture it whenever the output
                // slot is free or being consumed.
                if (!w_valid_q || w_ready_i) begin
                    w_data_d  = weight_data_i;
                    w_idx_d   = waddr_q;
                    w_valid_d = 1'b1;
                    if (waddr_q == W_LAST) begin
                        state_d = W_DRAIN;
                    end else begin
                        waddr_d = waddr_q + 1'b1;
                    end
                end
            end

            W_DRAIN: begin
                // Wait for the last weight beat to be taken before any fmap
                // beat can appear, keeping the two valids mutually exclusive.
                if (!w_valid_q || w_ready_i) begin
                    w_valid_d = 1'b0;
                    faddr_d   = '0;
                    state_d   = F_FETCH;
                end
            end

            F_FETCH: begin
                cs = 2'b01;
                if (!f_valid_q || f_ready_i) begin
                    f_data_d  = fmaps_data_i;
                    f_idx_d   = faddr_q;
                    f_valid_d = 1'b1;
                    if (faddr_q == F_LAST) begin
                        state_d = F_DRAIN;
                    end else begin
                        faddr_d = faddr_q + 1'b1;
                    end
                end
            end

            F_DRAIN: begin
                if (!f_valid_q || f_ready_i) begin
                    f_valid_d = 1'b0;
                    state_d   = DONE;
                end
            end

            DONE: begin
                w_valid_d = 1'b0;
                f_valid_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign glb_cs_o      = cs;
    assign glb_we_o      = 2'b00;
    assign fmaps_addr_o  = faddr_q;
    assign weight_addr_o = waddr_q;
    assign w_data_o      = w_data_q;
    assign w_idx_o       = w_idx_q;
    assign w_valid_o     = w_valid_q;
    assign f_data_o      = f_data_q;
    assign f_idx_o       = f_idx_q;
    assign f_valid_o     = f_valid_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);

endmodule
